// File: rtl/cache_assoc_wb.sv
// Set-associative write-back, write-allocate cache level, one word per line.
// Age-based LRU replacement, per-line dirty bits and a full write-back flush.
module cache_assoc_wb #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 1,
    parameter int WAYS    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              hit,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int TAG_W  = ADDR_W - INDEX_W;
    localparam int WAY_SH = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINES  = SETS * WAYS;
    localparam int LINE_W = $clog2(LINES);
    localparam int CNT_W  = LINE_W + 1;

    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(LINES);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    state_t state;
    state_t next_state;

    // Line storage, flattened as line = set * WAYS + way.
    logic              line_valid [LINES];
    logic              line_dirty [LINES];
    logic [TAG_W-1:0]  line_tag   [LINES];
    logic [DATA_W-1:0] line_data  [LINES];
    logic [WAY_W-1:0]  line_age   [LINES];

    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [WAY_W-1:0]  victim;
    logic [DATA_W-1:0] fill_data;
    logic [CNT_W-1:0]  scan_idx;

    logic [INDEX_W-1:0] set_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit_any;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_any;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   lru_way;
    logic [WAY_W-1:0]   pick_way;
    logic [LINE_W-1:0]  hit_line;
    logic [LINE_W-1:0]  pick_line;
    logic [LINE_W-1:0]  vic_line;
    logic [LINE_W-1:0]  scan_line;
    logic [INDEX_W-1:0] scan_set;
    logic               touch_en;
    logic [WAY_W-1:0]   touch_way;
    logic [WAY_W-1:0]   touch_age;

    function automatic logic [LINE_W-1:0] line_of(
        input logic [INDEX_W-1:0] set,
        input logic [WAY_W-1:0]   way
    );
        return (LINE_W'(set) << WAY_SH) + LINE_W'(way);
    endfunction

    assign set_idx   = req_addr[INDEX_W-1:0];
    assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
    assign pick_way  = inv_any ? inv_way : lru_way;
    assign hit_line  = line_of(set_idx, hit_way);
    assign pick_line = line_of(set_idx, pick_way);
    assign vic_line  = line_of(set_idx, victim);
    assign scan_line = scan_idx[LINE_W-1:0];
    assign scan_set  = INDEX_W'(scan_line >> WAY_SH);
    assign touch_age = line_age[line_of(set_idx, touch_way)];

    // Tag compare and victim choice across the ways of the latched set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_valid[line_of(set_idx, WAY_W'(w))] &&
                line_tag[line_of(set_idx, WAY_W'(w))] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_any && !line_valid[line_of(set_idx, WAY_W'(w))]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (line_age[line_of(set_idx, WAY_W'(w))] == AGE_MAX) begin
                lru_way = WAY_W'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake outputs and the LRU touch request.
    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        hit        = 1'b0;
        cpu_rdata  = '0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        touch_en   = 1'b0;
        touch_way  = '0;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    next_state = FLUSH_SCAN;
                end else if (cpu_req) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    cpu_ready  = 1'b1;
                    hit        = 1'b1;
                    cpu_rdata  = req_we ? req_wdata : line_data[hit_line];
                    touch_en   = 1'b1;
                    touch_way  = hit_way;
                    next_state = IDLE;
                end else if (line_valid[pick_line] && line_dirty[pick_line]) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag[vic_line], set_idx};
                mem_wdata = line_data[vic_line];
                if (mem_ack) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (mem_ack) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                cpu_ready  = 1'b1;
                cpu_rdata  = req_we ? req_wdata : fill_data;
                touch_en   = 1'b1;
                touch_way  = victim;
                next_state = IDLE;
            end
            FLUSH_SCAN: begin
                if (scan_idx == SCAN_END) begin
                    flush_done = 1'b1;
                    next_state = IDLE;
                end else if (line_valid[scan_line] && line_dirty[scan_line]) begin
                    next_state = FLUSH_WB;
                end
            end
            FLUSH_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag[scan_line], scan_set};
                mem_wdata = line_data[scan_line];
                if (mem_ack) begin
                    next_state = FLUSH_SCAN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Line arrays, request latch, refill capture, flush cursor and ages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < LINES; l++) begin
                line_valid[l] <= 1'b0;
                line_dirty[l] <= 1'b0;
                line_tag[l]   <= '0;
                line_data[l]  <= '0;
                line_age[l]   <= WAY_W'(l % WAYS);
            end
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            victim    <= '0;
            fill_data <= '0;
            scan_idx  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    scan_idx <= '0;
                    if (!flush_req && cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    victim <= pick_way;
                    if (hit_any && req_we) begin
                        line_data[hit_line]  <= req_wdata;
                        line_dirty[hit_line] <= 1'b1;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                    end
                end
                FILL: begin
                    line_valid[vic_line] <= 1'b1;
                    line_tag[vic_line]   <= req_tag;
                    line_data[vic_line]  <= req_we ? req_wdata : fill_data;
                    line_dirty[vic_line] <= req_we;
                end
                FLUSH_SCAN: begin
                    if (scan_idx != SCAN_END &&
                        !(line_valid[scan_line] && line_dirty[scan_line])) begin
                        scan_idx <= scan_idx + CNT_W'(1);
                    end
                end
                FLUSH_WB: begin
                    if (mem_ack) begin
                        line_dirty[scan_line] <= 1'b0;
                        scan_idx <= scan_idx + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way) begin
                        line_age[line_of(set_idx, WAY_W'(w))] <= '0;
                    end else if (line_age[line_of(set_idx, WAY_W'(w))] < touch_age) begin
                        line_age[line_of(set_idx, WAY_W'(w))] <=
                            line_age[line_of(set_idx, WAY_W'(w))] + WAY_W'(1);
                    end
                end
            end
        end
    end

endmodule
